// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, FSM state type and the 64-bit result bundle.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    // True for the multi-cycle arithmetic ops (MULT/MULTU/DIV/DIVU).
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the divide ops, which use the longer latency.
    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for MULT/MULTU/DIV/DIVU.
// Division works on magnitudes so 0x80000000 / 0xFFFFFFFF and x/0 never
// reach the language's undefined signed-overflow or divide-by-zero cases.
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output md_result_t  o_result,
    output logic        o_div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    assign w_signed_div = (i_op == MD_DIV);
    assign w_a_neg      = w_signed_div & i_a[31];
    assign w_b_neg      = w_signed_div & i_b[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag      = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_b_safe     = (i_b == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_safe;
    assign w_r_mag      = w_a_mag % w_b_safe;
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign w_q          = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r          = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // Select the result for the requested op.
    always_comb begin
        o_result      = '0;
        o_div_by_zero = 1'b0;
        case (i_op)
            MD_MULT:  o_result = {w_prod_s[63:32], w_prod_s[31:0]};
            MD_MULTU: o_result = {w_prod_u[63:32], w_prod_u[31:0]};
            MD_DIV, MD_DIVU: begin
                o_result      = {w_r, w_q};
                o_div_by_zero = (i_b == 32'd0);
            end
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// The full result is computed at the start edge and held as pending;
// the RUN state only counts out the architectural latency before commit.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_MAX = ((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) - 1;
    localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_commit;

    md_result_t       w_result;
    logic             w_div_by_zero;

    md_calc u_calc (
        .i_op          (op),
        .i_a           (rs_val),
        .i_b           (rt_val),
        .o_result      (w_result),
        .o_div_by_zero (w_div_by_zero)
    );

    // Control FSM: accept ops in IDLE, count down in RUN, commit HI/LO at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_commit  <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        if (md_is_arith(op)) begin
                            r_pend_hi <= w_result.hi;
                            r_pend_lo <= w_result.lo;
                            r_commit  <= ~w_div_by_zero;
                            r_cnt     <= md_is_div(op) ? DIV_LOAD : MULT_LOAD;
                            r_busy    <= 1'b1;
                            r_state   <= MD_RUN;
                        end else if (op == MD_MTHI) begin
                            r_hi <= rs_val;
                        end else if (op == MD_MTLO) begin
                            r_lo <= rs_val;
                        end
                    end
                end
                MD_RUN: begin
                    if (r_cnt == '0) begin
                        if (r_commit) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= MD_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: reset, arithmetic results, latency,
// divide-by-zero, signed overflow, ignored starts and MTHI/MTLO.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests;
    int n_fail;
    int cnt;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; returns in the first cycle after the start edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Counts busy-high cycles from now; bounded so a stuck busy fails the count check.
    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        rs_val  = '0;
        rt_val  = '0;

        // Reset state
        #12;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Reset during RUN: MULT 3x4, reset on busy cycle 2
        issue(3'd0, 32'd3, 32'd4);
        check("rstrun_busy_before", {31'd0, busy}, 32'd1);
        tick();
        #2 reset = 1'b0;
        #1;
        check("rstrun_busy", {31'd0, busy}, 32'd0);
        check("rstrun_hi", hi, 32'h0);
        check("rstrun_lo", lo, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("rstrun_nolate_busy", {31'd0, busy}, 32'd0);
        check("rstrun_nolate_lo", lo, 32'h0);
        check("rstrun_nolate_hi", hi, 32'h0);

        // MULT / MULTU
        issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_busy(cnt);
        check("mult_cycles", cnt, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);
        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_busy(cnt);
        check("multu_cycles", cnt, 32'd5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // DIV / DIVU
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_busy(cnt);
        check("div_cycles", cnt, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        issue(3'd3, 32'd7, 32'd2);
        wait_busy(cnt);
        check("divu_cycles", cnt, 32'd10);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        // Divide by zero leaves HI/LO untouched
        issue(3'd4, 32'h0000_AAAA, 32'd0);
        check("mthi_pre_busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'h0000_5555, 32'd0);
        check("mtlo_pre_lo", lo, 32'h0000_5555);
        check("mthi_pre_hi", hi, 32'h0000_AAAA);
        issue(3'd2, 32'd123, 32'd0);
        wait_busy(cnt);
        check("div0_cycles", cnt, 32'd10);
        check("div0_hi", hi, 32'h0000_AAAA);
        check("div0_lo", lo, 32'h0000_5555);

        // Signed overflow
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy(cnt);
        check("ovf_cycles", cnt, 32'd10);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        // Starts during busy are ignored
        issue(3'd0, 32'd2, 32'd3);
        tick();
        tick();
        check("sdb_busy_c3", {31'd0, busy}, 32'd1);
        op = 3'd5; rs_val = 32'h1234; rt_val = 32'd0; start = 1'b1;
        tick();
        check("sdb_busy_c4", {31'd0, busy}, 32'd1);
        check("sdb_lo_c4", lo, 32'h8000_0000);
        op = 3'd2; rs_val = 32'd9; rt_val = 32'd4;
        tick();
        start = 1'b0;
        check("sdb_busy_c5", {31'd0, busy}, 32'd1);
        tick();
        check("sdb_busy_end", {31'd0, busy}, 32'd0);
        check("sdb_hi", hi, 32'h0);
        check("sdb_lo", lo, 32'd6);
        for (int i = 0; i < 3; i++) tick();
        check("sdb_busy_after", {31'd0, busy}, 32'd0);
        check("sdb_lo_after", lo, 32'd6);

        // Start in the cycle busy falls is ignored
        issue(3'd1, 32'd5, 32'd5);
        for (int i = 1; i < 5; i++) tick();
        check("fall_busy_last", {31'd0, busy}, 32'd1);
        op = 3'd4; rs_val = 32'h77; start = 1'b1;
        tick();
        start = 1'b0;
        check("fall_busy", {31'd0, busy}, 32'd0);
        check("fall_hi", hi, 32'h0);
        check("fall_lo", lo, 32'd25);
        tick();
        check("fall_hi_next", hi, 32'h0);

        // MTHI in IDLE, back-to-back MTLO
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mthi_lo", lo, 32'd25);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        op = 3'd5; rs_val = 32'd1; start = 1'b1;
        tick();
        check("mtlo1_lo", lo, 32'd1);
        rs_val = 32'd2;
        tick();
        start = 1'b0;
        check("mtlo2_lo", lo, 32'd2);
        check("mtlo2_busy", {31'd0, busy}, 32'd0);

        // Reserved ops do nothing
        op = 3'd6; rs_val = 32'hFFFF; rt_val = 32'd3; start = 1'b1;
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        check("rsv_busy", {31'd0, busy}, 32'd0);
        check("rsv_hi", hi, 32'hDEAD_BEEF);
        check("rsv_lo", lo, 32'd2);

        // Operand changes during RUN have no effect
        issue(3'd0, 32'd6, 32'd7);
        rs_val = 32'd100;
        rt_val = 32'd100;
        wait_busy(cnt);
        check("opchg_cycles", cnt, 32'd5);
        check("opchg_lo", lo, 32'd42);
        check("opchg_hi", hi, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the Execute stage, directly downstream of the decode-to-execute pipeline register.
- Consumes the operand values that register presents and owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and MTHI/MTLO in a single cycle.
- Exposes busy to the hazard unit, which stalls MFHI/MFLO and further MD instructions.

Parameters:
- MULT_CYCLES, 5, cycles from accepted start to HI/LO commit for multiply.
- DIV_CYCLES, 10, cycles from accepted start to HI/LO commit for divide.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to launch the op on op this cycle.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6-7 reserved (no-op).
- rs_val  input  32  operand A: dividend/multiplicand, or the MTHI/MTLO source.
- rt_val  input  32  operand B: divisor/multiplier.
- busy  output  1  a multiply/divide is in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: reset low clears hi, lo, busy, counter and pending result immediately, independent of clk. Reset low mid-operation discards the operation with no commit.
- States: IDLE and RUN.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU, at the clk edge:
  - Operands are captured and the full 64-bit result is latched into pending_hi/pending_lo.
  - counter loads MULT_CYCLES-1 or DIV_CYCLES-1, and the state goes to RUN.
  - busy rises in the cycle after start, so the edge-to-busy latency is 1.
- RUN: counter decrements each edge. On the edge where counter==0, hi/lo load the pending values, busy falls, and the state returns to IDLE.
  - Total: busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - The new hi/lo are visible in the same cycle busy is first low.
- Start while busy: ignored entirely. No op restart, and MTHI/MTLO are also ignored. The hazard unit must not issue, and the bench checks that nothing changes.
- MTHI/MTLO in IDLE: hi (or lo) takes rs_val at the next edge. busy stays low. The other register is unchanged.
- Reserved op codes with start=1: no state change.
- Arithmetic:
  - MULT: signed 32x32 to 64-bit; hi=[63:32], lo=[31:0].
  - MULTU: the same, unsigned.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundary conditions:
  - Divide by zero (rt_val==0): the unit still goes busy for DIV_CYCLES, but hi/lo are unchanged at commit.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This case must not trap or produce X.
  - The result is fully determined at the start edge, so operand changes during RUN have no effect.
  - A start in the same cycle busy falls is ignored, because the state is still RUN. A new operation is accepted from the next cycle.
- The counter is sized to hold max(MULT_CYCLES, DIV_CYCLES)-1; DIV_CYCLES=10 needs 4 bits.

Decomposition:
- Shared package md_pkg holds:
  - The op encodings (MD_MULT .. MD_MTLO) as localparams, shared with the decoder and the hazard unit.
  - The default latency constants.
- Optional sub-module md_calc: combinational 64-bit result generation covering sign handling, div-by-zero flag and the overflow case, kept separate so it can be unit-tested alone.
- The state, counter and HI/LO registers stay in md_unit.

Test Plan:
- Reset during RUN: start MULT 3x4, assert reset low on cycle 2 -> hi=lo=0 and busy=0 immediately; after release, no late commit occurs.
- MULT 0xFFFFFFFF x 0x00000002 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. The same operands under MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> busy high exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- Divide by zero: preload via MTHI 0xAAAA, MTLO 0x5555, then DIV x/0 -> busy 10 cycles, hi=0xAAAA and lo=0x5555 unchanged. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start during busy: MULT 2x3, then on the 3rd busy cycle start MTLO 0x1234 and start DIV 9/4 -> both ignored; final hi=0, lo=6, and busy goes low after 5 cycles total.
- MTHI 0xDEADBEEF in IDLE -> hi updates next edge with busy never asserted, lo unchanged. Back-to-back MTLO 1 then MTLO 2 -> lo=2.
